// File: rtl/calc_datapath.sv
// Calculator datapath: captures operands on sequencer write-state entry and runs
// add/sub in one cycle, mul (shift-add) and div (restoring) over WIDTH cycles.
module calc_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           state,
  input  logic [WIDTH-1:0]     sw,
  input  logic [1:0]           op_sel,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 neg,
  output logic                 err,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] ST_OP1_WR = 3'b010;
  localparam logic [2:0] ST_OP2_WR = 3'b100;
  localparam logic [2:0] ST_CALC   = 3'b101;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  logic [2:0]         prev_state;
  logic               ent_wr1, ent_wr2, ent_calc;
  logic [1:0]         wk_op;
  logic [CW-1:0]      cnt;
  logic               last;

  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier;

  logic [WIDTH-1:0]   dvsr, quo, quo_nxt;
  logic [WIDTH:0]     rem, rem_sh, rem_try, rem_nxt;

  logic [WIDTH:0]     sum;
  logic               a_lt_b;
  logic [WIDTH-1:0]   abs_diff;

  assign ent_wr1  = (state == ST_OP1_WR) && (prev_state != ST_OP1_WR);
  assign ent_wr2  = (state == ST_OP2_WR) && (prev_state != ST_OP2_WR);
  assign ent_calc = (state == ST_CALC)   && (prev_state != ST_CALC);
  assign last     = (cnt == CW'(WIDTH - 1));

  always_comb begin
    sum      = {1'b0, op_a} + {1'b0, op_b};
    a_lt_b   = (op_a < op_b);
    abs_diff = a_lt_b ? (op_b - op_a) : (op_a - op_b);

    acc_nxt  = mplier[0] ? (acc + mcand) : acc;

    // Borrow out of the trial subtraction (MSB) means the divisor did not fit.
    rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_try  = rem_sh - {1'b0, dvsr};
    rem_nxt  = rem_try[WIDTH] ? rem_sh : rem_try;
    quo_nxt  = {quo[WIDTH-2:0], ~rem_try[WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      neg        <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wk_op      <= '0;
      cnt        <= '0;
      mcand      <= '0;
      acc        <= '0;
      mplier     <= '0;
      dvsr       <= '0;
      quo        <= '0;
      rem        <= '0;
    end else begin
      prev_state <= state;
      done       <= 1'b0;

      if (ent_wr1) op_a <= sw;
      if (ent_wr2) op_b <= sw;

      if (busy) begin
        cnt <= cnt + 1'b1;
        if (wk_op == OP_MUL) begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (last) begin
            result <= acc_nxt;
            neg    <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end else begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          if (last) begin
            result <= {rem_nxt[WIDTH-1:0], quo_nxt};
            neg    <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
      end else if (ent_calc) begin
        wk_op <= op_sel;
        cnt   <= '0;
        case (op_sel)
          OP_ADD: begin
            result <= {{(WIDTH-1){1'b0}}, sum};
            neg    <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b1;
          end
          OP_SUB: begin
            result <= {{WIDTH{1'b0}}, abs_diff};
            neg    <= a_lt_b;
            err    <= 1'b0;
            done   <= 1'b1;
          end
          OP_MUL: begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, op_a};
            mplier <= op_b;
            busy   <= 1'b1;
          end
          default: begin
            if (op_b == '0) begin
              result <= '1;
              neg    <= 1'b0;
              err    <= 1'b1;
              done   <= 1'b1;
            end else begin
              rem  <= '0;
              quo  <= op_a;
              dvsr <= op_b;
              busy <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_calc_datapath.sv
// Scoreboard bench for calc_datapath: stimulus pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_calc_datapath;
  logic        clk;
  logic        reset;
  logic [2:0]  state;
  logic [7:0]  sw;
  logic [1:0]  op_sel;
  logic [7:0]  op_a, op_b;
  logic [15:0] result;
  logic        neg, err, busy, done;

  calc_datapath #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .state(state), .sw(sw), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .result(result), .neg(neg), .err(err),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic        n;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_done = 0;
  logic last_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        n_done++;
        chk("done_single_cycle", {31'd0, last_done}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {16'd0, result}, {16'd0, e.r});
          chk("neg", {31'd0, neg}, {31'd0, e.n});
          chk("err", {31'd0, err}, {31'd0, e.e});
        end
      end
      last_done = done;
    end
  end

  task automatic drive(input logic [2:0] s, input logic [7:0] v);
    @(negedge clk);
    state = s;
    sw    = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(3'b000, 8'h00);
  endtask

  // Walk the sequencer through both write states, dwelling with different sw values.
  task automatic load(input logic [7:0] a, input logic [7:0] b);
    drive(3'b001, 8'h11);
    drive(3'b010, a);
    drive(3'b010, ~a);
    drive(3'b010, 8'hA5);
    drive(3'b011, 8'h5A);
    drive(3'b100, b);
    drive(3'b100, ~b);
    drive(3'b100, 8'h3C);
  endtask

  // Enter calculate, optionally re-enter it at negedge reent, and time done/busy.
  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [15:0] er, input logic en,
                        input logic ee, input int exp_lat, input int exp_busy,
                        input int reent);
    int lat;
    int bc;
    bit got;
    exp_t e;
    load(a, b);
    @(negedge clk);
    state  = 3'b101;
    op_sel = op;
    sw     = 8'hC3;
    e.r = er; e.n = en; e.e = ee;
    exp_q.push_back(e);
    lat = 0; bc = 0; got = 0;
    while (lat < 20 && !got) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) got = 1;
      state = (lat == reent) ? 3'b101 : 3'b000;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_busy_cycles"}, bc, exp_busy);
    chk({nm, "_op_a"}, {24'd0, op_a}, {24'd0, a});
    chk({nm, "_op_b"}, {24'd0, op_b}, {24'd0, b});
    idle(12);
  endtask

  initial begin
    int dcount;
    int lat;
    reset  = 1'b1;
    state  = 3'b000;
    sw     = 8'h00;
    op_sel = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_result", {16'd0, result}, 32'd0);
    chk("reset_op_a", {24'd0, op_a}, 32'd0);
    chk("reset_op_b", {24'd0, op_b}, 32'd0);
    chk("reset_flags", {28'd0, neg, err, busy, done}, 32'd0);
    reset = 1'b0;
    idle(2);

    run_op("add",  8'd200, 8'd100, 2'b00, 16'h012C, 1'b0, 1'b0, 1, 0, 0);
    run_op("sub1", 8'd5,   8'd9,   2'b01, 16'h0004, 1'b1, 1'b0, 1, 0, 0);
    run_op("sub2", 8'd9,   8'd5,   2'b01, 16'h0004, 1'b0, 1'b0, 1, 0, 0);
    run_op("mul",  8'd255, 8'd255, 2'b10, 16'hFE01, 1'b0, 1'b0, 9, 8, 0);
    run_op("div",  8'd100, 8'd7,   2'b11, 16'h020E, 1'b0, 1'b0, 9, 8, 0);
    run_op("div0", 8'd100, 8'd0,   2'b11, 16'hFFFF, 1'b0, 1'b1, 1, 0, 0);
    run_op("busy_reenter", 8'd3, 8'd4, 2'b10, 16'h000C, 1'b0, 1'b0, 9, 8, 2);

    // Reset in the middle of a multiply: nothing completes, everything clears.
    load(8'd3, 8'd4);
    @(negedge clk);
    state  = 3'b101;
    op_sel = 2'b10;
    lat = 0;
    while (lat < 4) begin
      @(negedge clk);
      lat++;
      state = 3'b000;
    end
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_op_a", {24'd0, op_a}, 32'd0);
    chk("abort_op_b", {24'd0, op_b}, 32'd0);
    reset  = 1'b0;
    dcount = n_done;
    idle(15);
    chk("abort_no_done", n_done - dcount, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
